instr_mem_access: RTL
=====================

INSTR_MEM_ACCESS -- requirements
Module: instr_mem_access

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 The block SHALL have these ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- valid_in, input, 1: execute-stage outputs are valid.
- instruction_in, input, XLEN: instruction from execute.
- alu_in, input, XLEN: ALU result, or effective address for LOAD/STORE.
- store_data_in, input, XLEN: store data (rs2).
- stall_out, output, 1: upstream shall hold and not advance.
- dmem_req, output, 1: data memory request.
- dmem_we, output, 1: 1 = write.
- dmem_addr, output, XLEN: word-aligned address ({alu_in[31:2],2'b00}).
- dmem_be, output, 4: byte enables.
- dmem_wdata, output, XLEN: lane-aligned write data.
- dmem_gnt, input, 1: request accepted.
- dmem_rvalid, input, 1: read data valid.
- dmem_rdata, input, XLEN: read data.
- wb_valid, output, 1: writeback entry valid.
- wb_we, output, 1: register-file write enable.
- wb_rd, output, 5: destination register.
- wb_data, output, XLEN: writeback data.
- misalign_err, output, 1: one-cycle pulse on a misaligned access.

Function
REQ-003 The FSM SHALL have states IDLE, REQ and WAIT_R.
REQ-004 In IDLE, a valid LOAD/STORE that is aligned SHALL be captured into internal registers and move the FSM to REQ; stall_out SHALL assert combinationally in that same cycle.
REQ-005 In REQ, dmem_req SHALL be 1 with stable address, be, we and wdata until dmem_gnt=1.
REQ-006 On dmem_gnt in REQ: a store SHALL retire (wb_valid=1, wb_we=0) next cycle and go to IDLE; a load SHALL go to WAIT_R.
REQ-007 In WAIT_R, on dmem_rvalid the extended load data SHALL appear on wb_data with wb_valid=1 next cycle, and the FSM SHALL go to IDLE.
REQ-008 stall_out SHALL be 1 when state!=IDLE, or when state is IDLE and a capture occurs.
REQ-009 A non-memory valid instruction in IDLE SHALL register to the wb_* outputs with 1-cycle latency; wb_data=alu_in.
REQ-010 wb_we SHALL be 1 only for OP, OP_IMM, LUI, AUIPC, JAL, JALR and LOAD with rd!=0; wb_rd SHALL equal instruction[11:7].
REQ-011 Stores SHALL use these lanes:
- SB: be=1<<addr[1:0], byte replicated across all four lanes.
- SH: be=0011 or 1100 by addr[1], halfword replicated.
- SW: be=1111.
REQ-012 Loads SHALL select the addressed lane:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the word unchanged.
REQ-013 Misaligned accesses are defined as LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0.
REQ-014 A misaligned access SHALL issue no request, pulse misalign_err for 1 cycle, and retire with wb_we=0.
REQ-015 When valid_in=0 in IDLE, wb_valid SHALL be 0 next cycle.
REQ-016 dmem_rvalid outside WAIT_R and dmem_gnt outside REQ SHALL be ignored.
REQ-017 wb_valid, wb_we and misalign_err SHALL be 0 in every cycle where no retire occurs.

Reset
REQ-018 While rst=0, all of the following SHALL be 0: state (IDLE), dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, misalign_err and the captured registers.
REQ-019 Reset during REQ or WAIT_R SHALL abandon the access with no retire; a response arriving after reset release SHALL be ignored.

Structure
REQ-020 Opcode (LOAD, STORE, OP, ...), funct3 (LB..LHU, SB..SW) and the FSM state enum SHALL live in the shared package/define file.
REQ-021 Load lane-select and extension SHALL be one sub-module, load_align.

Verification
REQ-022 The bench SHALL cover:
- SW addr=0x104, data=0xDEADBEEF, gnt after 2 cycles: req held 3 cycles, be=1111, stall_out high until retire, wb_we=0.
- SB addr=0x203, data=0x000000A5: be=1000, wdata=0xA5A5A5A5.
- LB addr=0x101, rdata=0x0000_80_00, rd=5: wb_data=0xFFFFFF80, wb_we=1, wb_rd=5 one cycle after rvalid.
- LHU addr=0x102, rdata=0x8001_1234: wb_data=0x00008001.
- LW addr=0x102: no dmem_req, misalign_err pulses once, wb_we=0.
- ADD rd=0 with alu_in=7: wb_valid=1, wb_we=0; reset asserted in WAIT_R then late rvalid: no wb_valid, state IDLE.

Source files
------------

// File: rtl/instr_mem_access_pkg.sv
// instr_mem_access_pkg: RV32I opcodes, funct3 codes and FSM states shared by the memory stage.
package instr_mem_access_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD};
  endfunction
endpackage

// File: rtl/instr_mem_access_load_align.sv
// load_align: picks the addressed byte/halfword of a read word and sign/zero-extends it.
module load_align
  import instr_mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
           funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
           funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
           funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : rdata;
  end
endmodule

// File: rtl/instr_mem_access.sv
// instr_mem_access: memory stage issuing aligned load/store requests and retiring results to writeback.
module instr_mem_access
  import instr_mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] instruction_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] store_data_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err
);
  state_t          state;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [1:0]      off;
  logic            is_mem, mis, capture;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, ld_data;
  logic [2:0]      cap_f3;
  logic [4:0]      cap_rd;
  logic [1:0]      cap_off;
  always_comb begin
    op = instruction_in[6:0];
    f3 = instruction_in[14:12];
    rd = instruction_in[11:7];
    off = alu_in[1:0];
    is_mem = valid_in && (op == OPC_LOAD || op == OPC_STORE);
    mis = is_mem && ((f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00));
    capture = state == IDLE && is_mem && !mis;
    stall_out = state != IDLE || capture;
    be = f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = f3[1:0] == 2'b00 ? {4{store_data_in[7:0]}} :
            f3[1:0] == 2'b01 ? {2{store_data_in[15:0]}} : store_data_in;
  end
  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3(cap_f3),
    .offset(cap_off),
    .rdata (dmem_rdata),
    .data  (ld_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      misalign_err <= 1'b0;
      cap_f3 <= '0;
      cap_rd <= '0;
      cap_off <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state <= REQ;
            dmem_req <= 1'b1;
            dmem_we <= op == OPC_STORE;
            dmem_addr <= {alu_in[XLEN-1:2], 2'b00};
            dmem_be <= be;
            dmem_wdata <= op == OPC_STORE ? wdata : '0;
            cap_f3 <= f3;
            cap_rd <= rd;
            cap_off <= off;
          end else if (valid_in) begin
            wb_valid <= 1'b1;
            wb_we <= writes_rd(op) && rd != 5'd0 && !mis;
            wb_rd <= rd;
            wb_data <= alu_in;
            misalign_err <= mis;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state <= dmem_we ? IDLE : WAIT_R;
            wb_valid <= dmem_we;
            wb_rd <= dmem_we ? cap_rd : wb_rd;
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            state <= IDLE;
            wb_valid <= 1'b1;
            wb_we <= cap_rd != 5'd0;
            wb_rd <= cap_rd;
            wb_data <= ld_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
